// File: rtl/ps2_num_input_pkg.sv
// ps2_num_input_pkg: scancodes, rx state encoding and digit decode shared by the keyboard path
package ps2_num_input_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;
  // returns {is_digit, value}
  function automatic logic [4:0] scan_digit(input logic [7:0] c);
    case (c)
      SC_0: scan_digit = 5'h10;
      SC_1: scan_digit = 5'h11;
      SC_2: scan_digit = 5'h12;
      SC_3: scan_digit = 5'h13;
      SC_4: scan_digit = 5'h14;
      SC_5: scan_digit = 5'h15;
      SC_6: scan_digit = 5'h16;
      SC_7: scan_digit = 5'h17;
      SC_8: scan_digit = 5'h18;
      SC_9: scan_digit = 5'h19;
      default: scan_digit = 5'h00;
    endcase
  endfunction
endpackage

// File: rtl/ps2_num_input_if.sv
// ps2_num_input_if: value/strobe handshake between the keyboard input path and the CPU in port
interface ps2_num_input_if #(parameter int DATA_WIDTH = 16);
  logic [DATA_WIDTH-1:0] in;
  logic                  control;
  logic                  pending;
  logic                  status;
  modport master (output in, output control, output pending, input status);
  modport slave  (input in, input control, input pending, output status);
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: synchronizes PS/2 lines and deframes 11-bit odd-parity frames into bytes
module ps2_rx
  import ps2_num_input_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [SYNC_STAGES-1:0] csync_q, csync_d, dsync_q, dsync_d;
  logic                   cprev_q, cprev_d;
  rx_state_e              state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d, byte_q, byte_d;
  logic                   par_q, par_d, valid_q, valid_d, ferr_q, ferr_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   fall, din;
  assign fall       = cprev_q & ~csync_q[SYNC_STAGES-1];
  assign din        = dsync_q[SYNC_STAGES-1];
  assign rx_byte    = byte_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;
  // frame FSM: shift bits on falling ps2_clk, check parity/stop, abort on silence
  always_comb begin
    csync_d = {csync_q[SYNC_STAGES-2:0], ps2_clk};
    dsync_d = {dsync_q[SYNC_STAGES-2:0], ps2_data};
    cprev_d = csync_q[SYNC_STAGES-1];
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    par_d   = par_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    tmo_d   = (state_q == RX_IDLE || fall) ? '0 : tmo_q + 1'b1;
    if (state_q != RX_IDLE && !fall && tmo_q == TW'(TIMEOUT - 1)) begin
      state_d = RX_IDLE;
      ferr_d  = 1'b1;
    end
    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          state_d = din ? RX_IDLE : RX_DATA;
          cnt_d   = '0;
          par_d   = 1'b0;
        end
        RX_DATA: begin
          shift_d = {din, shift_q[7:1]};
          par_d   = par_q ^ din;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == 3'd7) ? RX_PARITY : RX_DATA;
        end
        RX_PARITY: begin
          par_d   = par_q ^ din;
          state_d = RX_STOP;
        end
        default: begin
          state_d = RX_IDLE;
          valid_d = din & par_q;
          ferr_d  = ~(din & par_q);
          byte_d  = (din & par_q) ? shift_q : byte_q;
        end
      endcase
    end
  end
  // state register; sync chains reset to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csync_q <= '1;
      dsync_q <= '1;
      cprev_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      csync_q <= csync_d;
      dsync_q <= dsync_d;
      cprev_q <= cprev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      tmo_q   <= tmo_d;
    end
  end
endmodule

// File: rtl/ps2_num_input.sv
// ps2_num_input: decodes PS/2 digit keys into a decimal value delivered to the CPU on Enter
module ps2_num_input
  import ps2_num_input_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  ps2_num_input_if.master bus,
  output logic            err
);
  logic [7:0]            rx_byte;
  logic                  byte_valid, frame_err;
  logic                  ext_q, ext_d, brk_q, brk_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, in_q, in_d;
  logic                  pending_q, pending_d, control_q, control_d, err_q, err_d;
  logic [4:0]            dig;
  logic [DATA_WIDTH+3:0] prod;
  ps2_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );
  assign dig         = scan_digit(rx_byte);
  assign prod        = {4'b0, acc_q} * (DATA_WIDTH+4)'(10) + (DATA_WIDTH+4)'(dig[3:0]);
  assign bus.in      = in_q;
  assign bus.control = control_q;
  assign bus.pending = pending_q;
  assign err         = err_q;
  // prefix flags, accumulator, commit on Enter; handshake first so a same-cycle commit re-arms pending
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    acc_d     = acc_q;
    in_d      = in_q;
    control_d = pending_q & bus.status;
    pending_d = pending_q & ~bus.status;
    err_d     = err_q | frame_err;
    if (byte_valid) begin
      ext_d = (rx_byte == SC_EXT) | (ext_q & rx_byte == SC_BRK);
      brk_d = (rx_byte == SC_BRK) | (brk_q & rx_byte == SC_EXT);
      if (rx_byte != SC_EXT && rx_byte != SC_BRK && !ext_q && !brk_q) begin
        if (dig[4])
          acc_d = (|prod[DATA_WIDTH+3:DATA_WIDTH]) ? '1 : prod[DATA_WIDTH-1:0];
        if (rx_byte == SC_BKSP)
          acc_d = '0;
        if (rx_byte == SC_ENTER) begin
          in_d      = acc_q;
          acc_d     = '0;
          pending_d = 1'b1;
        end
      end
    end
  end
  // decoder and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      acc_q     <= '0;
      in_q      <= '0;
      pending_q <= 1'b0;
      control_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      acc_q     <= acc_d;
      in_q      <= in_d;
      pending_q <= pending_d;
      control_q <= control_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_ps2_num_input.sv
// tb_ps2_num_input: directed PS/2 frame stimulus with hand-computed CPU-side results
module tb_ps2_num_input;
  import ps2_num_input_pkg::*;
  localparam int TMO = 300;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic err;
  int   errors = 0;
  int   checks = 0;
  int   ctrl_cnt = 0;
  int   ctrl_wide = 0;
  logic ctrl_prev = 1'b0;
  ps2_num_input_if #(.DATA_WIDTH(16)) bus ();
  ps2_num_input #(.DATA_WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .bus     (bus),
    .err     (err)
  );
  always #10 clk = ~clk;
  always @(posedge clk) begin
    ctrl_prev <= bus.control;
    if (bus.control) ctrl_cnt <= ctrl_cnt + 1;
    if (bus.control && ctrl_prev) ctrl_wide <= ctrl_wide + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic bits(input logic [7:0] b, input bit bad, input int n);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask
  task automatic send(input logic [7:0] b, input bit bad = 1'b0);
    bits(b, bad, 11);
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask
  initial begin
    bus.status = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_in", 32'(bus.in), 0);
    chk("rst_control", 32'(bus.control), 0);
    chk("rst_pending", 32'(bus.pending), 0);
    chk("rst_err", 32'(err), 0);
    // 1: releases ignored, 12 delivered
    bus.status = 1'b1;
    send(SC_1); send(SC_BRK); send(SC_1); send(SC_2); send(SC_BRK); send(SC_2); send(SC_ENTER);
    chk("t1_in", 32'(bus.in), 12);
    chk("t1_ctrl", 32'(ctrl_cnt), 1);
    chk("t1_pending", 32'(bus.pending), 0);
    // 2: value waits while status low
    bus.status = 1'b0;
    send(SC_7); send(SC_ENTER);
    repeat (1000) @(negedge clk);
    chk("t2_pending", 32'(bus.pending), 1);
    chk("t2_ctrl_wait", 32'(ctrl_cnt), 1);
    chk("t2_in_early", 32'(bus.in), 7);
    bus.status = 1'b1;
    repeat (10) @(negedge clk);
    chk("t2_ctrl", 32'(ctrl_cnt), 2);
    chk("t2_pending_clr", 32'(bus.pending), 0);
    chk("t2_in", 32'(bus.in), 7);
    // 3: bad parity dropped
    send(SC_3, 1'b1);
    chk("t3_err", 32'(err), 1);
    chk("t3_acc", 32'(dut.acc_q), 0);
    send(SC_3); send(SC_ENTER);
    chk("t3_in", 32'(bus.in), 3);
    chk("t3_ctrl", 32'(ctrl_cnt), 3);
    // 4: timeout on a partial frame
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    chk("t4_err_rst", 32'(err), 0);
    bits(SC_4, 1'b0, 4);
    repeat (TMO + 10) @(negedge clk);
    chk("t4_err", 32'(err), 1);
    chk("t4_idle", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
    ps2_data = 1'b1;
    send(SC_4); send(SC_ENTER);
    chk("t4_in", 32'(bus.in), 4);
    chk("t4_ctrl", 32'(ctrl_cnt), 4);
    // 5: saturation, boundary and backspace
    for (int i = 0; i < 9; i++) send(SC_9);
    send(SC_ENTER);
    chk("t5_sat", 32'(bus.in), 32'hFFFF);
    send(SC_6); send(SC_5); send(SC_5); send(SC_3); send(SC_4); send(SC_ENTER);
    chk("t5_65534", 32'(bus.in), 65534);
    send(SC_6); send(SC_5); send(SC_5); send(SC_3); send(SC_6); send(SC_ENTER);
    chk("t5_65536", 32'(bus.in), 32'hFFFF);
    send(SC_0); send(SC_BKSP); send(SC_6); send(SC_ENTER);
    chk("t5_bksp", 32'(bus.in), 6);
    send(SC_0); send(SC_7); send(SC_ENTER);
    chk("t5_seven", 32'(bus.in), 7);
    chk("t5_ctrl", 32'(ctrl_cnt), 9);
    // 6: keypad Enter ignored, then async reset mid-frame
    send(SC_1); send(SC_EXT); send(SC_ENTER);
    chk("t6_no_commit", 32'(bus.pending), 0);
    chk("t6_in_kept", 32'(bus.in), 7);
    chk("t6_ctrl", 32'(ctrl_cnt), 9);
    bits(SC_2, 1'b0, 4);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_in_async", 32'(bus.in), 0);
    chk("t6_ctrl_async", 32'(bus.control), 0);
    chk("t6_pend_async", 32'(bus.pending), 0);
    chk("t6_err_async", 32'(err), 0);
    @(negedge clk) rst_n = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    send(SC_2); send(SC_ENTER);
    chk("t6_acc_clr", 32'(bus.in), 2);
    chk("t6_ctrl_end", 32'(ctrl_cnt), 10);
    chk("ctrl_width", 32'(ctrl_wide), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
